// File: rtl/branch_cmp_ctrl.sv
// ID-stage conditional branch resolution controller: operand-ready stalls,
// single-pulse resolve/pc_sel, saturating perf counters and a stall watchdog.
module branch_cmp_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_br_valid,
   input  logic [2:0]       i_br_type,
   input  logic             i_rs_ready,
   input  logic             i_rt_ready,
   input  logic             i_id_hold,
   input  logic             i_eq,
   input  logic             i_rs_sign,
   input  logic             i_rs_zero,
   output logic             o_stall,
   output logic             o_resolve,
   output logic             o_pc_sel,
   output logic             o_illegal,
   output logic             o_wd_err,
   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_taken_cnt,
   output logic [CNT_W-1:0] o_stall_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [7:0]       WD_LIM  = 8'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_wait_ctr;
   logic             r_illegal;
   logic             r_wd_err;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_need_rt;
   logic w_ops_ready;
   logic w_taken;
   logic w_stall;
   logic w_resolve;
   logic w_pc_sel;
   logic w_bad_type;

   assign w_need_rt   = (i_br_type == 3'd0) || (i_br_type == 3'd1);
   assign w_ops_ready = i_rs_ready & (i_rt_ready | ~w_need_rt);
   assign w_bad_type  = (i_br_type[2:1] == 2'b11);

   always_comb begin
      w_taken = 1'b0;
      unique case (i_br_type)
         3'd0:    w_taken = i_eq;
         3'd1:    w_taken = ~i_eq;
         3'd2:    w_taken = i_rs_sign | i_rs_zero;
         3'd3:    w_taken = ~i_rs_sign & ~i_rs_zero;
         3'd4:    w_taken = i_rs_sign;
         3'd5:    w_taken = ~i_rs_sign;
         default: w_taken = 1'b0;
      endcase
   end

   // Outputs are pure functions of this cycle's inputs; the front end
   // relies on zero-latency stall/redirect.
   assign w_stall   = i_br_valid & ~w_ops_ready;
   assign w_resolve = i_br_valid & w_ops_ready & ~i_id_hold;
   assign w_pc_sel  = w_resolve & w_taken;

   always_comb begin
      w_state_nxt = IDLE;
      if (!i_br_valid)
         w_state_nxt = IDLE;
      else if (!w_ops_ready)
         w_state_nxt = WAIT;
      else if (i_id_hold)
         w_state_nxt = HOLD;
      else
         w_state_nxt = IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // wait_ctr holds the number of stalled cycles already spent on this
   // branch, so the watchdog fires after exactly MAX_WAIT stalled cycles.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wait_ctr <= 8'd0;
         r_wd_err   <= 1'b0;
      end else begin
         if (w_state_nxt == WAIT) begin
            if (r_wait_ctr != 8'hff)
               r_wait_ctr <= r_wait_ctr + 8'd1;
         end else begin
            r_wait_ctr <= 8'd0;
         end
         if (w_stall && (r_wait_ctr == WD_LIM))
            r_wd_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_illegal <= 1'b0;
      end else if (w_resolve && w_bad_type) begin
         r_illegal <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_br_cnt    <= '0;
         r_taken_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_resolve && (r_br_cnt != CNT_MAX))
            r_br_cnt <= r_br_cnt + CNT_ONE;
         if (w_pc_sel && (r_taken_cnt != CNT_MAX))
            r_taken_cnt <= r_taken_cnt + CNT_ONE;
         if (w_stall && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   assign o_stall     = w_stall;
   assign o_resolve   = w_resolve;
   assign o_pc_sel    = w_pc_sel;
   assign o_illegal   = r_illegal;
   assign o_wd_err    = r_wd_err;
   assign o_br_cnt    = r_br_cnt;
   assign o_taken_cnt = r_taken_cnt;
   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// Directed bench for branch_cmp_ctrl (CNT_W=4, MAX_WAIT=8) with
// hand-computed expectations.
module tb_branch_cmp_ctrl;

   localparam int CNT_W    = 4;
   localparam int MAX_WAIT = 8;

   logic             clk;
   logic             reset;
   logic             br_valid;
   logic [2:0]       br_type;
   logic             rs_ready;
   logic             rt_ready;
   logic             id_hold;
   logic             eq;
   logic             rs_sign;
   logic             rs_zero;
   logic             stall;
   logic             resolve;
   logic             pc_sel;
   logic             illegal;
   logic             wd_err;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] taken_cnt;
   logic [CNT_W-1:0] stall_cnt;

   int n_cmp;
   int n_bad;

   branch_cmp_ctrl #(
      .CNT_W    (CNT_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_br_valid  (br_valid),
      .i_br_type   (br_type),
      .i_rs_ready  (rs_ready),
      .i_rt_ready  (rt_ready),
      .i_id_hold   (id_hold),
      .i_eq        (eq),
      .i_rs_sign   (rs_sign),
      .i_rs_zero   (rs_zero),
      .o_stall     (stall),
      .o_resolve   (resolve),
      .o_pc_sel    (pc_sel),
      .o_illegal   (illegal),
      .o_wd_err    (wd_err),
      .o_br_cnt    (br_cnt),
      .o_taken_cnt (taken_cnt),
      .o_stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and are sampled 1-2 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] t,
                        input logic rs, input logic rt, input logic h,
                        input logic e, input logic s, input logic z);
      br_valid = v;
      br_type  = t;
      rs_ready = rs;
      rt_ready = rt;
      id_hold  = h;
      eq       = e;
      rs_sign  = s;
      rs_zero  = z;
      settle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      settle();
   endtask

   typedef struct {
      logic [2:0] t;
      logic       e;
      logic       s;
      logic       z;
      logic       tk;
   } tvec_t;

   tvec_t tv[10];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      do_reset();

      chk("rst_stall", stall, 0);
      chk("rst_resolve", resolve, 0);
      chk("rst_pc_sel", pc_sel, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_wd_err", wd_err, 0);
      chk("rst_br_cnt", br_cnt, 0);
      chk("rst_taken_cnt", taken_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);

      // beq, operands ready, equal -> taken same cycle
      drive(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("beq_resolve", resolve, 1);
      chk("beq_pc_sel", pc_sel, 1);
      chk("beq_stall", stall, 0);
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("beq_br_cnt", br_cnt, 1);
      chk("beq_taken_cnt", taken_cnt, 1);

      // bne waits 3 cycles on rt, then resolves not-taken (eq=1)
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         chk("bne_wait_stall", stall, 1);
         chk("bne_wait_resolve", resolve, 0);
         tick();
      end
      drive(1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("bne_stall_off", stall, 0);
      chk("bne_resolve", resolve, 1);
      chk("bne_pc_sel", pc_sel, 0);
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bne_stall_cnt", stall_cnt, 3);
      chk("bne_br_cnt", br_cnt, 2);
      chk("bne_taken_cnt", taken_cnt, 1);

      // bgez ignores rt readiness
      drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bgez_stall", stall, 0);
      chk("bgez_resolve", resolve, 1);
      chk("bgez_pc_sel", pc_sel, 1);
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bgez_br_cnt", br_cnt, 3);
      chk("bgez_taken_cnt", taken_cnt, 2);

      // blez held by id_hold for 2 cycles: no stall, no decision
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
         chk("hold_stall", stall, 0);
         chk("hold_resolve", resolve, 0);
         chk("hold_pc_sel", pc_sel, 0);
         tick();
      end
      chk("hold_br_cnt", br_cnt, 3);
      drive(1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("blez_resolve", resolve, 1);
      chk("blez_pc_sel", pc_sel, 1);
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("blez_br_cnt", br_cnt, 4);
      chk("blez_taken_cnt", taken_cnt, 3);
      chk("blez_stall_cnt", stall_cnt, 3);

      // stall is independent of id_hold
      drive(1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("stall_w_hold", stall, 1);
      chk("stall_w_hold_res", resolve, 0);
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("squash_stall", stall, 0);

      // watchdog: rs never ready for 10 cycles
      for (int n = 1; n <= 10; n++) begin
         drive(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("wd_stall", stall, 1);
         tick();
         if (n == 7) chk("wd_err_c7", wd_err, 0);
         if (n == 8) chk("wd_err_c8", wd_err, 1);
         if (n == 10) chk("wd_err_c10", wd_err, 1);
      end
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("wd_sticky", wd_err, 1);
      chk("wd_br_cnt", br_cnt, 4);
      chk("wd_stall_cnt", stall_cnt, 13);
      do_reset();
      chk("wd_rst_err", wd_err, 0);
      chk("wd_rst_stall_cnt", stall_cnt, 0);
      chk("wd_rst_br_cnt", br_cnt, 0);

      // Short waits separated by squashes must not trip the watchdog
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 5; n++) begin
            drive(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
         end
         drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      chk("wd_squash_clear", wd_err, 0);
      chk("stall_cnt_sat", stall_cnt, 15);
      do_reset();

      // taken-condition table, resolved back to back
      tv[0] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[1] = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
      tv[2] = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b1};
      tv[3] = '{3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[4] = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
      tv[5] = '{3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[6] = '{3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
      tv[7] = '{3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[8] = '{3'd5, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[9] = '{3'd6, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, tv[i].t, 1'b1, 1'b1, 1'b0, tv[i].e, tv[i].s, tv[i].z);
         chk($sformatf("tbl%0d_pc_sel", i), pc_sel, int'(tv[i].tk));
         chk($sformatf("tbl%0d_resolve", i), resolve, 1);
         tick();
      end
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tbl_br_cnt", br_cnt, 10);
      chk("tbl_taken_cnt", taken_cnt, 4);
      chk("tbl_illegal6", illegal, 1);
      do_reset();
      chk("rst_illegal2", illegal, 0);

      // 20 taken beq back to back saturate both counters at 15
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
         if (i == 13) chk("sat_br_cnt_14", br_cnt, 14);
      end
      chk("sat_br_cnt", br_cnt, 15);
      chk("sat_taken_cnt", taken_cnt, 15);
      chk("sat_illegal_pre", illegal, 0);

      drive(1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("ill_resolve", resolve, 1);
      chk("ill_pc_sel", pc_sel, 0);
      tick();
      drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill_set", illegal, 1);
      tick();
      chk("ill_sticky", illegal, 1);
      chk("ill_br_cnt", br_cnt, 15);

      // reset mid-wait: branch re-stalls, wait restarts from zero
      for (int n = 0; n < 6; n++) begin
         drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      chk("rstw_stall", stall, 1);
      chk("rstw_stall_cnt", stall_cnt, 0);
      for (int n = 0; n < 7; n++) tick();
      chk("rstw_wd_c7", wd_err, 0);
      tick();
      chk("rstw_wd_c8", wd_err, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_cmp_ctrl.md
Name: branch_cmp_ctrl

Overview:
ID-stage branch resolution controller that sequences the operand equality comparator (A==B) and rs sign/zero flags for all six conditional branches.
- Decides when comparator operands are valid and stalls the front end until they are.
- Issues a single resolve/PC-select decision per branch instance.
- Keeps saturating performance counters and a stall watchdog.
- Sits between the hazard unit, the ID-stage comparator and the NPC mux.

Parameters:
CNT_W, 16, width of each performance counter (saturating)
MAX_WAIT, 8, consecutive operand-wait cycles before the watchdog flags an error (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
br_valid  in  1  conditional branch present in ID this cycle
br_type  in  3  0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez, 6/7 illegal
rs_ready  in  1  forwarded rs value valid (no pending load/producer)
rt_ready  in  1  forwarded rt value valid
id_hold  in  1  ID stage frozen by another stall source (e.g. mult/div busy)
eq  in  1  comparator output, 1 when rs==rt
rs_sign  in  1  forwarded rs[31]
rs_zero  in  1  forwarded rs==0
stall  out  1  freeze PC/IF-ID because branch operands not ready
resolve  out  1  branch decided this cycle (one pulse per branch instance)
pc_sel  out  1  select branch target in NPC mux
illegal  out  1  sticky: illegal br_type was resolved
wd_err  out  1  sticky: watchdog expired
br_cnt  out  CNT_W  branches resolved
taken_cnt  out  CNT_W  branches taken
stall_cnt  out  CNT_W  cycles stall asserted

Behaviour:
- Operand requirements:
  - need_rt = (br_type==0 | br_type==1).
  - ops_ready = rs_ready & (rt_ready | !need_rt).
- Taken condition:
  - beq: eq. bne: !eq.
  - blez: rs_sign|rs_zero. bgtz: !rs_sign&!rs_zero.
  - bltz: rs_sign. bgez: !rs_sign.
  - Types 6/7: not taken.
- Combinational outputs (zero latency; pipeline depends on this):
  - stall = br_valid & !ops_ready.
  - resolve = br_valid & ops_ready & !id_hold.
  - pc_sel = resolve & taken.
  - stall is independent of id_hold.
- FSM, states IDLE, WAIT, HOLD; next state is evaluated every cycle:
  - Any state, br_valid=0 -> IDLE. This covers a branch squashed mid-wait: no resolve, no counter update.
  - br_valid & !ops_ready -> WAIT.
  - br_valid & ops_ready & id_hold -> HOLD. Decision is withheld; pc_sel stays 0.
  - br_valid & ops_ready & !id_hold -> IDLE, with resolve pulsed.
  - Back-to-back branches: resolve in cycle N and br_valid with a new branch in N+1 is legal; the new branch is evaluated independently.
- Watchdog:
  - wait_ctr (8 bit) increments every cycle the FSM is in WAIT and stall=1. It clears on leaving WAIT.
  - When wait_ctr reaches MAX_WAIT-1 while stall=1, wd_err sets on the next edge.
  - wd_err stays set until reset; stall is unaffected.
- Counters, all saturating at 2^CNT_W-1 (no wrap):
  - br_cnt += resolve.
  - taken_cnt += pc_sel.
  - stall_cnt += stall.
  - Multiple increments in the same cycle are all applied.
- illegal: set on the edge after resolve with br_type 6/7; sticky until reset.
- Reset (synchronous, wins over all events):
  - state=IDLE; wait_ctr, counters, wd_err and illegal all = 0.
  - Combinational outputs follow their equations, so with br_valid=0 they are 0.
  - Reset mid-WAIT discards the wait; the branch re-stalls if br_valid is still high after reset.

Test Plan:
- beq, rs_ready=rt_ready=1, eq=1, id_hold=0 -> resolve=1 and pc_sel=1 in the same cycle; br_cnt=1, taken_cnt=1 next cycle.
- bne, rt_ready=0 for 3 cycles then 1, eq=1 -> stall=1 for 3 cycles, stall_cnt=3; then resolve=1, pc_sel=0, taken_cnt unchanged.
- bgez with rt_ready=0, rs_ready=1, rs_sign=0 -> no stall (rt not needed); resolve=1, pc_sel=1.
- blez ready with id_hold=1 for 2 cycles -> state HOLD, resolve=0, pc_sel=0; when id_hold drops: resolve=1, pc_sel=1 (rs_zero=1), br_cnt increments once.
- MAX_WAIT=8, rs_ready=0 held 10 cycles -> wd_err=1 after the 8th stalled cycle and stays 1; drop br_valid -> IDLE, br_cnt=0; reset -> wd_err=0, stall_cnt=0.
- CNT_W=4: 20 taken beq resolves -> br_cnt=taken_cnt=15 (saturated); br_type=7 resolve -> pc_sel=0, illegal=1 next cycle.
